// File: rtl/mmu_access_unit.sv
// Load/store access unit: latches one CPU request, drives the TLB, resolves segment
// mapping / alignment / TLB exceptions, then runs a single req/ack bus transaction.
module mmu_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned TIMEOUT_WIDTH  = 8
) (
    input  logic        clk,
    input  logic        res,
    input  logic        cpuReq,
    input  logic        cpuWe,
    input  logic [1:0]  cpuSize,
    input  logic [31:0] cpuAddr,
    input  logic [31:0] cpuWData,
    input  logic        userMode,
    output logic        cpuBusy,
    output logic        cpuDone,
    output logic [31:0] cpuRData,
    output logic        exc,
    output logic [4:0]  excCode,
    output logic        tlbRefill,
    output logic [31:0] badVAddr,
    output logic [31:0] tlbVAddr,
    input  logic [31:0] tlbPAddr,
    input  logic        tlbFound,
    input  logic        tlbV,
    input  logic        tlbD,
    output logic        busReq,
    output logic        busWe,
    output logic [31:0] busAddr,
    output logic [3:0]  busBe,
    output logic [31:0] busWData,
    input  logic [31:0] busRData,
    input  logic        busAck
);

    typedef enum logic [2:0] {StIdle, StXlate, StBus, StDone, StExc} state_e;

    localparam logic [TIMEOUT_WIDTH-1:0] TimeoutLimit = TIMEOUT_CYCLES[TIMEOUT_WIDTH-1:0];
    localparam logic [TIMEOUT_WIDTH-1:0] CntOne = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};

    state_e                   state_q, state_d;
    logic [31:0]              addr_q, addr_d;
    logic                     we_q, we_d;
    logic [1:0]               size_q, size_d;
    logic [31:0]              wdata_q, wdata_d;
    logic                     user_q, user_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]              rdata_q, rdata_d;
    logic [4:0]               code_q, code_d;
    logic                     refill_q, refill_d;
    logic [31:0]              baddr_q, baddr_d;
    logic [3:0]               be_q, be_d;
    logic [31:0]              bwdata_q, bwdata_d;
    logic                     bwe_q, bwe_d;

    logic        is_word, is_half, misalign, priv_viol, unmapped;
    logic [3:0]  be;
    logic [31:0] rep_data;
    logic [4:0]  addr_code, tlb_code;

    // Access classification of the latched request
    always_comb begin
        is_word   = size_q[1];
        is_half   = (size_q == 2'd1);
        misalign  = (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00));
        priv_viol = user_q && addr_q[31];
        unmapped  = (addr_q[31:29] == 3'b100) || (addr_q[31:29] == 3'b101);
        addr_code = we_q ? 5'd5 : 5'd4;
        tlb_code  = we_q ? 5'd3 : 5'd2;
        if (is_word) begin
            be       = 4'b1111;
            rep_data = wdata_q;
        end else if (is_half) begin
            be       = addr_q[1] ? 4'b1100 : 4'b0011;
            rep_data = {2{wdata_q[15:0]}};
        end else begin
            be       = 4'b0001 << addr_q[1:0];
            rep_data = {4{wdata_q[7:0]}};
        end
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        size_d   = size_q;
        wdata_d  = wdata_q;
        user_d   = user_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        code_d   = code_q;
        refill_d = refill_q;
        baddr_d  = baddr_q;
        be_d     = be_q;
        bwdata_d = bwdata_q;
        bwe_d    = bwe_q;
        unique case (state_q)
            StIdle: begin
                if (cpuReq) begin
                    addr_d  = cpuAddr;
                    we_d    = cpuWe;
                    size_d  = cpuSize;
                    wdata_d = cpuWData;
                    user_d  = userMode;
                    state_d = StXlate;
                end
            end
            StXlate: begin
                refill_d = 1'b0;
                if (misalign || priv_viol) begin
                    code_d  = addr_code;
                    state_d = StExc;
                end else if (!unmapped && !tlbFound) begin
                    code_d   = tlb_code;
                    refill_d = 1'b1;
                    state_d  = StExc;
                end else if (!unmapped && !tlbV) begin
                    code_d  = tlb_code;
                    state_d = StExc;
                end else if (!unmapped && we_q && !tlbD) begin
                    code_d  = 5'd1;
                    state_d = StExc;
                end else begin
                    // Segment-mapped addresses strip the top three bits; mapped ones use the TLB
                    baddr_d  = (unmapped ? {3'b000, addr_q[28:0]} : tlbPAddr) & 32'hFFFF_FFFC;
                    be_d     = be;
                    bwdata_d = rep_data;
                    bwe_d    = we_q;
                    cnt_d    = '0;
                    state_d  = StBus;
                end
            end
            StBus: begin
                if (busAck) begin
                    rdata_d = busRData;
                    state_d = StDone;
                end else if ((TIMEOUT_CYCLES != 0) && ((cnt_q + CntOne) == TimeoutLimit)) begin
                    code_d   = 5'd7;
                    refill_d = 1'b0;
                    state_d  = StExc;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StDone:  state_d = StIdle;
            StExc:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            we_q     <= 1'b0;
            size_q   <= '0;
            wdata_q  <= '0;
            user_q   <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            code_q   <= '0;
            refill_q <= 1'b0;
            baddr_q  <= '0;
            be_q     <= '0;
            bwdata_q <= '0;
            bwe_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            size_q   <= size_d;
            wdata_q  <= wdata_d;
            user_q   <= user_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            code_q   <= code_d;
            refill_q <= refill_d;
            baddr_q  <= baddr_d;
            be_q     <= be_d;
            bwdata_q <= bwdata_d;
            bwe_q    <= bwe_d;
        end
    end

    // Strobes decode straight from state so reset clears them without waiting for a clock
    always_comb begin
        cpuBusy   = (state_q != StIdle);
        cpuDone   = (state_q == StDone);
        exc       = (state_q == StExc);
        busReq    = (state_q == StBus);
        cpuRData  = rdata_q;
        excCode   = code_q;
        tlbRefill = refill_q;
        badVAddr  = addr_q;
        tlbVAddr  = addr_q;
        busAddr   = baddr_q;
        busBe     = be_q;
        busWData  = bwdata_q;
        busWe     = bwe_q;
    end

endmodule
